// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_substractor.sv
// One-bit full subtractor cell: y = a - b - bin, x = borrow out.
module substractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic y,
    output logic x
);

    assign y = a ^ b ^ bin;
    assign x = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, through a
// single full-subtractor cell; result appears after WIDTH shift cycles.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [CW-1:0]    count;
    logic             bor;
    logic             d;
    logic             bout;

    substractor u_cell (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (bor),
        .y   (d),
        .x   (bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result bits enter at the MSB and walk right, so after WIDTH shifts
    // the first (LSB) difference bit lands in diff_sr[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            count   <= '0;
            bor     <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr    <= a;
            b_sr    <= b;
            diff_sr <= '0;
            count   <= '0;
            bor     <= 1'b0;
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= {d, diff_sr[WIDTH-1:1]};
            count   <= count + 1'b1;
            bor     <= bout;
        end
    end

    assign busy       = (state == SHIFT);
    assign done       = (state == DONE);
    assign diff       = diff_sr;
    assign borrow_out = bor;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: minuend (unsigned), captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend (unsigned), captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 SHALL have port diff, output, WIDTH bits: (a - b) mod 2^WIDTH.
REQ-010 SHALL have port borrow_out, output, 1 bit: 1 iff a < b (unsigned).

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 at edge E0, SHALL load a and b into operand shift registers, clear the borrow flop and the bit counter, clear diff, and enter SHIFT.
REQ-013 In IDLE with start=0, SHALL remain in IDLE and hold diff and borrow_out unchanged.
REQ-014 Each SHIFT edge SHALL form d = a0 ^ b0 ^ bor and bout = (~a0 & b0) | (~(a0 ^ b0) & bor), using the LSBs of the operand registers.
REQ-015 Each SHIFT edge SHALL shift d into the MSB of diff (right shift), shift both operand registers right by one, load bout into the borrow flop, and increment the counter.
REQ-016 After exactly WIDTH SHIFT edges (E1..EW), SHALL enter DONE and present the final borrow on borrow_out.
REQ-017 SHALL assert done only in DONE (one cycle, from EW to EW+1), then return to IDLE at EW+1 unconditionally.
REQ-018 diff and borrow_out SHALL stay stable from EW until the next accepted start.
REQ-019 start SHALL be ignored in SHIFT and DONE; operand inputs SHALL be ignored except at acceptance.
REQ-020 The counter SHALL be $clog2(WIDTH+1) bits wide; no wrap-around may occur within an operation.
REQ-021 busy and done SHALL be decoded from state only, never both high.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, and borrow flop=0, regardless of clk.
REQ-023 rst asserted mid-operation SHALL abort it with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-024 State encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in a shared package/include with the default WIDTH.
REQ-025 The bit-cell logic of REQ-014 SHALL be one instance of the team's existing one-bit full subtractor cell substractor (ports a, b, borrow in; y difference, x borrow out).
REQ-026 Only the FSM, counter, shift registers, and borrow flop SHALL be sequential.

Verification
REQ-027 WIDTH=8, a=5, b=3, start pulse -> busy high 8 cycles, done pulse, diff=0x02, borrow_out=0.
REQ-028 a=3, b=5 -> diff=0xFE, borrow_out=1; a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
REQ-029 a=b=0xA5 -> diff=0x00, borrow_out=0; then a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0.
REQ-030 start held high with new operands during SHIFT -> first result unaffected; second operation begins only after return to IDLE.
REQ-031 rst pulse in 4th SHIFT cycle -> all outputs 0 immediately, no done; next start a=9, b=4 -> diff=0x05, borrow_out=0.
REQ-032 Randomized 200 operand pairs -> diff and borrow_out match (a - b) mod 256 and (a < b) each time.
